issuequeue_ooo: RTL and testbench

- Parametrised out-of-order successor to the in-order issue queue; sits between dispatch and one execute pipe.
- Holds up to DEPTH renamed instructions, each with two source-ready states woken by NUM_WB writeback ports.
- Each cycle, issues the oldest entry whose sources are both ready, and discards entries younger than a redirect.
- Instruction payload is opaque (PAYLOAD_W bits); the queue interprets only physical register tags, ROB index and source states.

---
 rtl/issuequeue_ooo_pkg.sv | 28 ++
 rtl/issuequeue_ooo_age.sv | 32 +++
 rtl/issuequeue_ooo.sv | 168 ++++++++++++++++
 tb/tb_issuequeue_ooo.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issuequeue_ooo_pkg.sv
// Shared types and helpers for the out-of-order issue queue.
// Entry fields use the default tag and ROB widths defined here.
package issuequeue_ooo_pkg;

  localparam int PREG_W_DFLT  = 6;
  localparam int ROB_LOG_DFLT = 6;

  typedef struct packed {
    logic                    valid;
    logic [PREG_W_DFLT-1:0]  prs1;
    logic [PREG_W_DFLT-1:0]  prs2;
    logic                    is_reg1;
    logic                    is_reg2;
    logic                    busy1;
    logic                    busy2;
    logic                    rob_flag;
    logic [ROB_LOG_DFLT-1:0] robidx;
  } entry_t;

  // True when ROB position a is younger than ROB position b (wrap flag aware).
  function automatic logic rob_younger(input logic                    a_flag,
                                       input logic [ROB_LOG_DFLT-1:0] a_idx,
                                       input logic                    b_flag,
                                       input logic [ROB_LOG_DFLT-1:0] b_idx);
    return (a_flag ^ b_flag) ^ (b_idx < a_idx);
  endfunction

endpackage

// File: rtl/issuequeue_ooo_age.sv
// Age matrix: older[i][j]=1 means entry j was enqueued before entry i.
// Produces the one-hot oldest entry among the ready vector.
module issue_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DEPTH-1:0] enq_onehot,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] oldest
);

  logic [DEPTH-1:0] older [DEPTH];

  // A new entry is younger than every valid entry; nobody sees it as older.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_onehot[i]) older[i] <= valid & ~enq_onehot;
        else               older[i] <= older[i] & ~enq_onehot;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) oldest[i] = ready[i] & ~|(ready & older[i]);
  end

endmodule

// File: rtl/issuequeue_ooo.sv
// Out-of-order issue queue: wakeup, oldest-ready select, ROB-ordered flush.
// Define ISSUEQUEUE_PERF_CNT_EN to add the performance counter outputs.
module issuequeue_ooo
  import issuequeue_ooo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = PREG_W_DFLT,
  parameter int ROB_LOG   = ROB_LOG_DFLT,
  parameter int NUM_WB    = 2,
  parameter int PAYLOAD_W = 128
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [PREG_W-1:0]        enq_prs1,
  input  logic [PREG_W-1:0]        enq_prs2,
  input  logic                     enq_src1_is_reg,
  input  logic                     enq_src2_is_reg,
  input  logic                     enq_src1_busy,
  input  logic                     enq_src2_busy,
  input  logic                     enq_robidx_flag,
  input  logic [ROB_LOG-1:0]       enq_robidx,
  input  logic [PAYLOAD_W-1:0]     enq_payload,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [PREG_W-1:0]        deq_prs1,
  output logic [PREG_W-1:0]        deq_prs2,
  output logic                     deq_robidx_flag,
  output logic [ROB_LOG-1:0]       deq_robidx,
  output logic [PAYLOAD_W-1:0]     deq_payload,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*PREG_W-1:0] wb_prd,
  input  logic                     flush_valid,
  input  logic                     flush_robidx_flag,
  input  logic [ROB_LOG-1:0]       flush_robidx,
`ifdef ISSUEQUEUE_PERF_CNT_EN
  output logic [31:0]              perf_issue_cnt,
  output logic [31:0]              perf_full_cycles,
  output logic [31:0]              perf_stall_ready_cycles,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  entry_t                 entries  [DEPTH];
  logic [PAYLOAD_W-1:0]   payloads [DEPTH];
  entry_t                 new_entry;
  logic [DEPTH-1:0]       valid_vec, free_vec, ready_vec, flush_hit, oldest, enq_onehot;
  logic                   enq_fire, issue;
  logic [PREG_W-1:0]      sel_prs1, sel_prs2;
  logic                   sel_flag;
  logic [ROB_LOG-1:0]     sel_robidx;
  logic [PAYLOAD_W-1:0]   sel_payload;

  function automatic logic woken(input logic [PREG_W-1:0] tag);
    woken = 1'b0;
    for (int p = 0; p < NUM_WB; p++)
      if (wb_valid[p] && wb_prd[p*PREG_W +: PREG_W] == tag) woken = 1'b1;
  endfunction

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries[i].valid;
      flush_hit[i] = flush_valid & entries[i].valid &
                     rob_younger(entries[i].rob_flag, entries[i].robidx,
                                 flush_robidx_flag, flush_robidx);
      ready_vec[i] = entries[i].valid & ~entries[i].busy1 & ~entries[i].busy2 & ~flush_hit[i];
      count        = count + CNT_W'(entries[i].valid);
    end
  end

  assign enq_ready = ~flush_valid & (count != CNT_W'(DEPTH));
  assign enq_fire  = enq_valid & enq_ready;
  assign free_vec  = ~valid_vec;
  // Isolating the lowest set bit picks the lowest-index free slot.
  assign enq_onehot = enq_fire ? (free_vec & (~free_vec + DEPTH'(1))) : '0;
  assign issue     = (|oldest) & deq_ready;

  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.prs1     = enq_prs1;
    new_entry.prs2     = enq_prs2;
    new_entry.is_reg1  = enq_src1_is_reg;
    new_entry.is_reg2  = enq_src2_is_reg;
    new_entry.busy1    = enq_src1_busy & enq_src1_is_reg & ~woken(enq_prs1);
    new_entry.busy2    = enq_src2_busy & enq_src2_is_reg & ~woken(enq_prs2);
    new_entry.rob_flag = enq_robidx_flag;
    new_entry.robidx   = enq_robidx;
  end

  issue_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clock      (clock),
    .reset      (reset),
    .enq_onehot (enq_onehot),
    .valid      (valid_vec),
    .ready      (ready_vec),
    .oldest     (oldest)
  );

  always_comb begin
    sel_prs1    = '0;
    sel_prs2    = '0;
    sel_flag    = 1'b0;
    sel_robidx  = '0;
    sel_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oldest[i]) begin
        sel_prs1    = entries[i].prs1;
        sel_prs2    = entries[i].prs2;
        sel_flag    = entries[i].rob_flag;
        sel_robidx  = entries[i].robidx;
        sel_payload = payloads[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deq_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      deq_valid <= issue;
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_onehot[i]) begin
          entries[i] <= new_entry;
        end else if (entries[i].valid) begin
          if ((issue && oldest[i]) || flush_hit[i]) entries[i].valid <= 1'b0;
          if (entries[i].is_reg1 && woken(entries[i].prs1)) entries[i].busy1 <= 1'b0;
          if (entries[i].is_reg2 && woken(entries[i].prs2)) entries[i].busy2 <= 1'b0;
        end
      end
    end
  end

  // NOTE: payload storage and deq data carry no reset; valid bits gate every read.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++)
      if (enq_onehot[i]) payloads[i] <= enq_payload;
    if (issue) begin
      deq_prs1        <= sel_prs1;
      deq_prs2        <= sel_prs2;
      deq_robidx_flag <= sel_flag;
      deq_robidx      <= sel_robidx;
      deq_payload     <= sel_payload;
    end
  end

`ifdef ISSUEQUEUE_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_issue_cnt          <= '0;
      perf_full_cycles        <= '0;
      perf_stall_ready_cycles <= '0;
    end else begin
      if (issue && perf_issue_cnt != '1) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (count == CNT_W'(DEPTH) && perf_full_cycles != '1)
        perf_full_cycles <= perf_full_cycles + 32'd1;
      if ((|ready_vec) && !deq_ready && perf_stall_ready_cycles != '1)
        perf_stall_ready_cycles <= perf_stall_ready_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issuequeue_ooo.sv
// Self-checking bench for issuequeue_ooo: sequence-number reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_issuequeue_ooo;

  localparam int DEPTH = 8, PREG_W = 6, ROB_LOG = 6, NUM_WB = 2, PAYLOAD_W = 128;

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic                     enq_valid = 1'b0, enq_ready;
  logic [PREG_W-1:0]        enq_prs1 = '0, enq_prs2 = '0;
  logic                     enq_src1_is_reg = 1'b0, enq_src2_is_reg = 1'b0;
  logic                     enq_src1_busy = 1'b0, enq_src2_busy = 1'b0;
  logic                     enq_robidx_flag = 1'b0;
  logic [ROB_LOG-1:0]       enq_robidx = '0;
  logic [PAYLOAD_W-1:0]     enq_payload = '0;
  logic                     deq_ready = 1'b0, deq_valid;
  logic [PREG_W-1:0]        deq_prs1, deq_prs2;
  logic                     deq_robidx_flag;
  logic [ROB_LOG-1:0]       deq_robidx;
  logic [PAYLOAD_W-1:0]     deq_payload;
  logic [NUM_WB-1:0]        wb_valid = '0;
  logic [NUM_WB*PREG_W-1:0] wb_prd = '0;
  logic                     flush_valid = 1'b0, flush_robidx_flag = 1'b0;
  logic [ROB_LOG-1:0]       flush_robidx = '0;
  logic [$clog2(DEPTH):0]   count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;
  int issued[$];

  issuequeue_ooo dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
    .enq_src1_is_reg(enq_src1_is_reg), .enq_src2_is_reg(enq_src2_is_reg),
    .enq_src1_busy(enq_src1_busy), .enq_src2_busy(enq_src2_busy),
    .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx), .enq_payload(enq_payload),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_prs1(deq_prs1), .deq_prs2(deq_prs2),
    .deq_robidx_flag(deq_robidx_flag), .deq_robidx(deq_robidx), .deq_payload(deq_payload),
    .wb_valid(wb_valid), .wb_prd(wb_prd),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag), .flush_robidx(flush_robidx),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Age is a monotonically increasing sequence number; ROB positions are 7-bit {flag,idx}.
  bit                   m_valid [DEPTH];
  int unsigned          m_seq   [DEPTH];
  bit                   m_b1 [DEPTH], m_b2 [DEPTH], m_r1 [DEPTH], m_r2 [DEPTH];
  int                   m_t1 [DEPTH], m_t2 [DEPTH], m_rob [DEPTH];
  logic [PAYLOAD_W-1:0] m_pay [DEPTH];
  int unsigned          next_seq;
  bit                   m_dv;
  int                   m_drob, m_dp1, m_dp2;
  logic [PAYLOAD_W-1:0] m_dpay;
  int                   win, slot;
  bit                   fh [DEPTH];
  bit                   ef, rdy;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic bit m_enq_ready();
    return !flush_valid && m_count() < DEPTH;
  endfunction

  function automatic bit wb_hit(input int tag);
    for (int p = 0; p < NUM_WB; p++)
      if (wb_valid[p] && int'(wb_prd[p*PREG_W +: PREG_W]) == tag) return 1'b1;
    return 1'b0;
  endfunction

  // Younger means the ROB distance from the flush point is within half the ring.
  function automatic bit m_younger(input int e, input int f);
    int d = (e - f) & 127;
    return d >= 1 && d <= 64;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 0; m_b1[i] = 0; m_b2[i] = 0;
      end
      m_dv = 0;
      next_seq = 0;
    end else begin
      ef = enq_valid && m_enq_ready();
      win = -1;
      slot = -1;
      for (int i = 0; i < DEPTH; i++) begin
        fh[i] = flush_valid && m_valid[i] &&
                m_younger(m_rob[i], {25'd0, flush_robidx_flag, flush_robidx});
        rdy = m_valid[i] && !m_b1[i] && !m_b2[i] && !fh[i];
        if (rdy && (win < 0 || m_seq[i] < m_seq[win])) win = i;
        if (!m_valid[i] && slot < 0) slot = i;
      end
      m_dv = (win >= 0) && deq_ready;
      if (m_dv) begin
        m_drob = m_rob[win]; m_dp1 = m_t1[win]; m_dp2 = m_t2[win]; m_dpay = m_pay[win];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (m_valid[i]) begin
          if (fh[i] || (m_dv && i == win)) m_valid[i] = 0;
          if (m_r1[i] && wb_hit(m_t1[i])) m_b1[i] = 0;
          if (m_r2[i] && wb_hit(m_t2[i])) m_b2[i] = 0;
        end
      end
      if (ef) begin
        m_valid[slot] = 1;
        m_seq[slot]   = next_seq++;
        m_r1[slot]    = enq_src1_is_reg;
        m_r2[slot]    = enq_src2_is_reg;
        m_t1[slot]    = int'(enq_prs1);
        m_t2[slot]    = int'(enq_prs2);
        m_b1[slot]    = enq_src1_busy && enq_src1_is_reg && !wb_hit(int'(enq_prs1));
        m_b2[slot]    = enq_src2_busy && enq_src2_is_reg && !wb_hit(int'(enq_prs2));
        m_rob[slot]   = {25'd0, enq_robidx_flag, enq_robidx};
        m_pay[slot]   = enq_payload;
      end
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("deq_valid", 128'(deq_valid), 128'(m_dv));
      if (m_dv && deq_valid === 1'b1) begin
        check("deq_rob", 128'({deq_robidx_flag, deq_robidx}), 128'(m_drob));
        check("deq_prs1", 128'(deq_prs1), 128'(m_dp1));
        check("deq_prs2", 128'(deq_prs2), 128'(m_dp2));
        check("deq_payload", deq_payload, m_dpay);
      end
      check("count", 128'(count), 128'(m_count()));
      check("enq_ready", 128'(enq_ready), 128'(m_enq_ready()));
    end
    if (deq_valid === 1'b1) issued.push_back(int'({deq_robidx_flag, deq_robidx}));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    enq_valid = 0; wb_valid = '0; flush_valid = 0;
  endtask

  task automatic set_enq(input bit fl, input int rob, input bit r1, input bit b1, input int t1,
                         input bit r2, input bit b2, input int t2);
    enq_valid       = 1;
    enq_robidx_flag = fl;
    enq_robidx      = ROB_LOG'(rob);
    enq_src1_is_reg = r1; enq_src1_busy = b1; enq_prs1 = PREG_W'(t1);
    enq_src2_is_reg = r2; enq_src2_busy = b2; enq_prs2 = PREG_W'(t2);
    enq_payload     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic enq_ready_entry(input bit fl, input int rob);
    set_enq(fl, rob, 1, 0, rob & 63, 1, 0, (rob + 1) & 63);
  endtask

  initial begin
    #1 reset = 1;
    #1 cmp_en = 1;
    check("reset_count", 128'(count), 128'd0);
    check("reset_deq_valid", 128'(deq_valid), 128'd0);
    check("reset_enq_ready", 128'(enq_ready), 128'd1);
    @(posedge clock); #2 reset = 0;

    // Wakeup in order: younger ready B issues before busy A.
    deq_ready = 1;
    idle(); set_enq(0, 1, 1, 1, 5, 0, 0, 0); cyc();
    idle(); set_enq(0, 2, 1, 0, 7, 1, 0, 8); cyc();
    idle(); cyc();
    check("wake_b_valid", 128'(deq_valid), 128'd1);
    check("wake_b_rob", 128'(deq_robidx), 128'd2);
    wb_valid = 2'b01; wb_prd = {6'd0, 6'd5}; cyc();
    idle();
    check("wake_a_not_yet", 128'(deq_valid), 128'd0);
    cyc();
    check("wake_a_valid", 128'(deq_valid), 128'd1);
    check("wake_a_rob", 128'(deq_robidx), 128'd1);
    idle(); cyc();

    // Age priority with back-to-back ready entries.
    issued.delete();
    for (int k = 0; k < 4; k++) begin
      idle(); enq_ready_entry(0, 3 + k); cyc();
    end
    idle(); repeat (4) cyc();
    check("age_n", 128'(issued.size()), 128'd4);
    for (int k = 0; k < 4 && k < issued.size(); k++)
      check("age_order", 128'(issued[k]), 128'(3 + k));

    // Age beats slot index: rob 22 lands in slot 0 but is younger than rob 21.
    issued.delete();
    deq_ready = 0; idle(); enq_ready_entry(0, 20); cyc();
    idle(); enq_ready_entry(0, 21); cyc();
    idle(); deq_ready = 1; cyc();
    deq_ready = 0; enq_ready_entry(0, 22); cyc();
    idle(); deq_ready = 1; repeat (4) cyc();
    check("slot_age_n", 128'(issued.size()), 128'd3);
    if (issued.size() == 3) begin
      check("slot_age_0", 128'(issued[0]), 128'd20);
      check("slot_age_1", 128'(issued[1]), 128'd21);
      check("slot_age_2", 128'(issued[2]), 128'd22);
    end

    // Full and backpressure; issue does not free a slot for same-cycle enqueue.
    deq_ready = 0;
    for (int k = 0; k < DEPTH; k++) begin
      idle(); enq_ready_entry(0, 30 + k); cyc();
    end
    issued.delete();
    idle(); enq_ready_entry(0, 40); deq_ready = 1; #1;
    check("full_enq_ready", 128'(enq_ready), 128'd0);
    check("full_count", 128'(count), 128'd8);
    cyc(); idle();
    check("drain_count_7", 128'(count), 128'd7);
    for (int i = 2; i <= DEPTH; i++) begin
      cyc();
      check("drain_count", 128'(count), 128'(DEPTH - i));
    end
    cyc();
    check("drain_n", 128'(issued.size()), 128'd8);
    if (issued.size() > 0) check("drain_first", 128'(issued[0]), 128'd30);

    // Flush across the ROB wrap: only the flag-1 entries are younger than (0,63).
    deq_ready = 0;
    idle(); enq_ready_entry(0, 62); cyc();
    idle(); enq_ready_entry(0, 63); cyc();
    idle(); enq_ready_entry(1, 0);  cyc();
    idle(); enq_ready_entry(1, 1);  cyc();
    idle(); enq_ready_entry(1, 2);
    flush_valid = 1; flush_robidx_flag = 0; flush_robidx = 6'd63; #1;
    check("flush_enq_ready", 128'(enq_ready), 128'd0);
    check("flush_count_before", 128'(count), 128'd4);
    cyc(); idle();
    check("flush_count_after", 128'(count), 128'd2);
    issued.delete(); deq_ready = 1; repeat (4) cyc();
    check("flush_n", 128'(issued.size()), 128'd2);
    if (issued.size() == 2) begin
      check("flush_keep_0", 128'(issued[0]), 128'd62);
      check("flush_keep_1", 128'(issued[1]), 128'd63);
    end

    // Same-cycle wakeup at enqueue (port 1 matches, port 0 does not).
    idle(); set_enq(0, 50, 1, 0, 4, 1, 1, 9);
    wb_valid = 2'b10; wb_prd = {6'd9, 6'd3}; cyc();
    idle(); cyc();
    check("enq_wake_valid", 128'(deq_valid), 128'd1);
    check("enq_wake_rob", 128'(deq_robidx), 128'd50);
    cyc();

    // Reset mid-operation.
    deq_ready = 0;
    for (int k = 0; k < 4; k++) begin
      idle(); enq_ready_entry(0, 55 + k); cyc();
    end
    idle(); deq_ready = 1; cyc();
    deq_ready = 0; #1;
    check("pre_reset_valid", 128'(deq_valid), 128'd1);
    check("pre_reset_count", 128'(count), 128'd3);
    reset = 1; #1;
    check("mid_reset_valid", 128'(deq_valid), 128'd0);
    check("mid_reset_count", 128'(count), 128'd0);
    @(posedge clock); #2 reset = 0;
    idle(); deq_ready = 1; enq_ready_entry(1, 60); cyc();
    idle();
    check("post_reset_count", 128'(count), 128'd1);
    cyc();
    check("post_reset_valid", 128'(deq_valid), 128'd1);
    check("post_reset_rob", 128'({deq_robidx_flag, deq_robidx}), 128'(64 + 60));
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
